// File: rtl/asym_fifo_ctrl_w2n_pkg.sv
// rtl/asym_fifo_ctrl_w2n_pkg.sv - shared constants and width helpers for the wide-to-narrow FIFO controller
package asym_fifo_ctrl_w2n_pkg;

  // Default geometry of the controlled asymmetric SDP RAM
  localparam int DEF_AWA = 8;
  localparam int DEF_DWA = 16;
  localparam int DEF_AWB = 10;
  localparam int DEF_DWB = 4;

  // RAM read latency in cycles (issue to ram_doutb valid)
  localparam int RD_LAT = 2;

  // Output buffer depth; also bounds reads in flight plus buffered words
  localparam int OB_DEPTH = 4;

  // Narrow words per wide word
  function automatic int ratio_f(input int dwa, input int dwb);
    return dwa / dwb;
  endfunction

  // Ceiling log2 for elaboration-time sizing
  function automatic int log2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int OB_PW = log2_f(OB_DEPTH);
  localparam int OB_CW = OB_PW + 1;

endpackage

// File: rtl/asym_fifo_ctrl_w2n_if.sv
// rtl/asym_fifo_ctrl_w2n_if.sv - stream, flush and RAM-port bundle of the wide-to-narrow FIFO controller
interface asym_fifo_ctrl_w2n_if
  import asym_fifo_ctrl_w2n_pkg::*;
#(
  parameter int AWA = DEF_AWA,
  parameter int DWA = DEF_DWA,
  parameter int AWB = DEF_AWB,
  parameter int DWB = DEF_DWB
) ();

  logic           clr;
  logic           s_valid;
  logic           s_ready;
  logic [DWA-1:0] s_data;
  logic           m_valid;
  logic           m_ready;
  logic [DWB-1:0] m_data;
  logic           ram_wea;
  logic [AWA-1:0] ram_addra;
  logic [DWA-1:0] ram_dina;
  logic           ram_reb;
  logic [AWB-1:0] ram_addrb;
  logic [DWB-1:0] ram_doutb;
  logic [AWB:0]   level;

  // Controller side
  modport slave (
    input  clr, s_valid, s_data, m_ready, ram_doutb,
    output s_ready, m_valid, m_data, ram_wea, ram_addra, ram_dina,
           ram_reb, ram_addrb, level
  );

  // Producer / consumer / RAM side
  modport master (
    output clr, s_valid, s_data, m_ready, ram_doutb,
    input  s_ready, m_valid, m_data, ram_wea, ram_addra, ram_dina,
           ram_reb, ram_addrb, level
  );

endinterface

// File: rtl/asym_fifo_outbuf.sv
// rtl/asym_fifo_outbuf.sv - small narrow-word output FIFO fed by returning RAM reads
module asym_fifo_outbuf
  import asym_fifo_ctrl_w2n_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [DW-1:0]    head,
  output logic [OB_CW-1:0] count,
  output logic             not_empty
);

  logic [DW-1:0]    mem_q [OB_DEPTH];
  logic [OB_PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [OB_CW-1:0] count_q, count_d;

  // Pointer and occupancy next state; push never overflows because the caller holds credits
  always_comb begin
    wp_d    = wp_q + OB_PW'(push);
    rp_d    = rp_q + OB_PW'(pop);
    count_d = count_q + OB_CW'(push) - OB_CW'(pop);
    if (clr) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Data storage needs no reset; it is only read when count says it is valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= push_data;
  end

  assign head      = mem_q[rp_q];
  assign count     = count_q;
  assign not_empty = (count_q != '0);

endmodule

// File: rtl/asym_fifo_ctrl_w2n.sv
// rtl/asym_fifo_ctrl_w2n.sv - wide-write / narrow-read FIFO controller around an asymmetric SDP RAM
module asym_fifo_ctrl_w2n
  import asym_fifo_ctrl_w2n_pkg::*;
#(
  parameter int AWA = DEF_AWA,
  parameter int DWA = DEF_DWA,
  parameter int AWB = DEF_AWB,
  parameter int DWB = DEF_DWB
) (
  input logic                clk,
  input logic                rst_n,
  asym_fifo_ctrl_w2n_if.slave bus
);

  localparam int           RATIO     = 1 << log2_f(ratio_f(DWA, DWB));
  localparam logic [AWB:0] RATIO_W   = (AWB + 1)'(RATIO);
  localparam logic [AWB:0] READY_MAX = (AWB + 1)'((1 << AWB) - RATIO);

  logic [AWA:0]        wptr_q, wptr_d;
  logic [AWB:0]        rptr_q, rptr_d;
  logic [AWB:0]        level_q, level_d;
  logic [AWB:0]        avail_q, avail_d, avail_eff;
  logic [1:0]          wr_pipe_q, wr_pipe_d;
  logic [RD_LAT-1:0]   inf_q, inf_d;
  logic [OB_CW-1:0]    ob_count;
  logic [OB_CW:0]      occ;
  logic [DWB-1:0]      ob_head;
  logic                ob_valid;
  logic                wr_fire, rd_issue, pop;

  // Write side: accept straight into the RAM write port
  assign bus.s_ready   = rst_n & ~bus.clr & (level_q <= READY_MAX);
  assign wr_fire       = bus.s_valid & bus.s_ready;
  assign bus.ram_wea   = wr_fire;
  assign bus.ram_addra = wptr_q[AWA-1:0];
  assign bus.ram_dina  = bus.s_data;

  // A wide write becomes readable two cycles after accept, once it has landed in the RAM
  assign avail_eff = avail_q + (wr_pipe_q[1] ? RATIO_W : '0);

  // Reads are credit-limited so every returning word has a buffer slot
  assign occ       = {1'b0, ob_count} + (OB_CW + 1)'($countones(inf_q));
  assign rd_issue  = ~bus.clr & (avail_eff != '0) & (occ < (OB_CW + 1)'(OB_DEPTH));
  assign bus.ram_reb   = rd_issue;
  assign bus.ram_addrb = rptr_q[AWB-1:0];

  assign pop         = ob_valid & bus.m_ready;
  assign bus.m_valid = ob_valid;
  assign bus.m_data  = ob_head;
  assign bus.level   = level_q;

  // Next state for pointers, counters and the commit/inflight pipelines; flush zeroes all
  always_comb begin
    wptr_d    = wptr_q + (AWA + 1)'(wr_fire);
    rptr_d    = rptr_q + (AWB + 1)'(rd_issue);
    level_d   = level_q + (wr_fire ? RATIO_W : '0) - (AWB + 1)'(pop);
    avail_d   = avail_eff - (AWB + 1)'(rd_issue);
    wr_pipe_d = {wr_pipe_q[0], wr_fire};
    inf_d     = {inf_q[RD_LAT-2:0], rd_issue};
    if (bus.clr) begin
      wptr_d    = '0;
      rptr_d    = '0;
      level_d   = '0;
      avail_d   = '0;
      wr_pipe_d = '0;
      inf_d     = '0;
    end
  end

  // Controller state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      avail_q   <= '0;
      wr_pipe_q <= '0;
      inf_q     <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      avail_q   <= avail_d;
      wr_pipe_q <= wr_pipe_d;
      inf_q     <= inf_d;
    end
  end

  // Returning data is captured only when tagged by the inflight pipeline
  asym_fifo_outbuf #(
    .DW(DWB)
  ) u_outbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (bus.clr),
    .push      (inf_q[RD_LAT-1]),
    .push_data (bus.ram_doutb),
    .pop       (pop),
    .head      (ob_head),
    .count     (ob_count),
    .not_empty (ob_valid)
  );

endmodule

// File: tb/tb_asym_fifo_ctrl_w2n.sv
// tb/tb_asym_fifo_ctrl_w2n.sv - scoreboard bench for the wide-to-narrow FIFO controller
`timescale 1ns/1ps
module tb_asym_fifo_ctrl_w2n;

  localparam int AWA   = 3;
  localparam int DWA   = 16;
  localparam int AWB   = 5;
  localparam int DWB   = 4;
  localparam int RATIO = DWA / DWB;
  localparam int CAP   = 1 << AWB;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  asym_fifo_ctrl_w2n_if #(.AWA(AWA), .DWA(DWA), .AWB(AWB), .DWB(DWB)) bus ();

  asym_fifo_ctrl_w2n #(.AWA(AWA), .DWA(DWA), .AWB(AWB), .DWB(DWB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [DWB-1:0] exp_q [$];
  int  wcnt = 0;
  bit  exp_rdy;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_miss++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // RAM behavioural model: write lands end of T+1, read data valid in R+2
  logic [DWA-1:0] ram_mem [1 << AWA];
  logic           wq_v;
  logic [AWA-1:0] wq_addr;
  logic [DWA-1:0] wq_data;
  logic           rd1_v;
  logic [DWB-1:0] rd1;
  always @(posedge clk) begin
    wq_v    <= bus.ram_wea;
    wq_addr <= bus.ram_addra;
    wq_data <= bus.ram_dina;
    if (wq_v) ram_mem[wq_addr] <= wq_data;
    rd1_v <= bus.ram_reb;
    rd1   <= bus.ram_reb ? ram_mem[bus.ram_addrb[AWB-1:2]][{bus.ram_addrb[1:0], 2'b00} +: DWB]
                         : DWB'($urandom);
    bus.ram_doutb <= rd1_v ? rd1 : DWB'($urandom);
  end

  // Monitor: checks state against the queue model, pops on output handshakes, records accepts
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_s_ready", int'(bus.s_ready), 0);
      chk("rst_m_valid", int'(bus.m_valid), 0);
      chk("rst_ram_wea", int'(bus.ram_wea), 0);
      chk("rst_ram_reb", int'(bus.ram_reb), 0);
      chk("rst_level",   int'(bus.level),   0);
      exp_q.delete();
      wcnt = 0;
    end else begin
      exp_rdy = !bus.clr && (exp_q.size() <= CAP - RATIO);
      chk("level",   int'(bus.level),   exp_q.size());
      chk("s_ready", int'(bus.s_ready), int'(exp_rdy));
      chk("ram_wea", int'(bus.ram_wea), int'(bus.s_valid && exp_rdy));
      if (bus.ram_wea) begin
        chk("ram_addra", int'(bus.ram_addra), wcnt % (1 << AWA));
        chk("ram_dina",  int'(bus.ram_dina),  int'(bus.s_data));
      end
      if (bus.m_valid) begin
        chk("m_valid_nonempty", int'(exp_q.size() > 0), 1);
        if (bus.m_ready && exp_q.size() > 0) begin
          chk("m_data", int'(bus.m_data), int'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (bus.clr) begin
        exp_q.delete();
        wcnt = 0;
      end else if (bus.s_valid && bus.s_ready) begin
        for (int i = 0; i < RATIO; i++) exp_q.push_back(bus.s_data[i*DWB +: DWB]);
        wcnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    k = 0;
    while (bus.level != '0 && k < 300) begin
      tick();
      k++;
    end
    @(negedge clk);
    chk("drain_level", int'(bus.level), 0);
    tick();
  endtask

  initial begin
    int lat, acc, pops, k;
    for (int i = 0; i < (1 << AWA); i++) ram_mem[i] = DWA'($urandom);
    rst_n = 1'b0;
    bus.clr = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Single write: latency and narrow order
    bus.s_data = 16'hDCBA;
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.m_valid && lat < 20);
    chk("first_read_latency", lat, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("burst_m_valid", int'(bus.m_valid), 1);
    end
    @(negedge clk);
    chk("single_level_end", int'(bus.level), 0);
    tick();

    // Fill to capacity with the consumer stalled
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 40 && acc < 8; i++) begin
      bus.s_data = DWA'($urandom);
      @(negedge clk);
      if (bus.s_ready) acc++;
      tick();
    end
    bus.s_valid = 1'b0;
    chk("fill_accepts", acc, 8);
    repeat (6) tick();
    @(negedge clk);
    chk("full_level", int'(bus.level), CAP);
    chk("full_s_ready", int'(bus.s_ready), 0);
    tick();
    for (int p = 0; p < 4; p++) begin
      k = 0;
      while (!bus.m_valid && k < 10) begin
        tick();
        k++;
      end
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
      @(negedge clk);
      chk("s_ready_after_pop", int'(bus.s_ready), int'(p == 3));
      tick();
    end
    drain();

    // Streaming across several pointer wraps: one narrow word per cycle once filled
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 120; i++) begin
      bus.s_data = DWA'($urandom);
      @(negedge clk);
      if (i >= 20 && bus.m_valid && bus.m_ready) pops++;
      tick();
    end
    chk("stream_throughput", pops, 100);
    drain();

    // Full-rate writes with a randomly stalling consumer
    bus.s_valid = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      bus.s_data  = DWA'($urandom);
      bus.m_ready = $urandom_range(0, 1) != 0;
      tick();
    end
    drain();

    // Flush with reads in flight and data buffered
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.s_data = DWA'($urandom);
      tick();
    end
    bus.m_ready = 1'b0;
    tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("clr_m_valid", int'(bus.m_valid), 0);
    chk("clr_level", int'(bus.level), 0);
    tick();
    bus.m_ready = 1'b1;
    repeat (8) tick();
    bus.s_data = 16'h1234;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    drain();

    // Asynchronous reset in the middle of traffic
    bus.s_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus.s_data  = DWA'($urandom);
      bus.m_ready = $urandom_range(0, 1) != 0;
      tick();
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_s_ready", int'(bus.s_ready), 0);
    chk("async_rst_m_valid", int'(bus.m_valid), 0);
    chk("async_rst_ram_wea", int'(bus.ram_wea), 0);
    chk("async_rst_ram_reb", int'(bus.ram_reb), 0);
    chk("async_rst_level",   int'(bus.level),   0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      bus.s_data  = DWA'($urandom);
      bus.s_valid = $urandom_range(0, 3) != 0;
      bus.m_ready = $urandom_range(0, 1) != 0;
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
